// File: rtl/fft_bram_pkg.sv
// Shared types and constants for the RFFT dual-port sample store.
package fft_bram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Packed complex word: real and imaginary halves of width bits each.
    function automatic int word_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/fft_bram_port_pipe.sv
// Per-port read-data/valid pipeline; data holds whenever the incoming slot is invalid.
module fft_bram_port_pipe #(
    parameter int DW      = 64,
    parameter int OUT_REG = 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Rd_Vld,
    input  logic [DW-1:0] Rd_Data,
    output logic [DW-1:0] DO,
    output logic          Vld
);

    logic [DW-1:0] s1_data_r;
    logic          s1_vld_r;

    // First output stage: capture read data only for accepted accesses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_data_r <= '0;
            s1_vld_r  <= 1'b0;
        end else begin
            s1_vld_r <= Rd_Vld;
            if (Rd_Vld) begin
                s1_data_r <= Rd_Data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] s2_data_r;
            logic          s2_vld_r;

            // Optional extra stage for timing closure.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    s2_data_r <= '0;
                    s2_vld_r  <= 1'b0;
                end else begin
                    s2_vld_r <= s1_vld_r;
                    if (s1_vld_r) begin
                        s2_data_r <= s1_data_r;
                    end
                end
            end

            assign DO  = s2_data_r;
            assign Vld = s2_vld_r;
        end else begin : g_no_out_reg
            assign DO  = s1_data_r;
            assign Vld = s1_vld_r;
        end
    endgenerate

endmodule

// File: rtl/fft_bram_dp.sv
// True dual-port complex-sample RAM with write arbitration, collision flag and
// a post-reset clear sequencer that zeroes the array before traffic is accepted.
module fft_bram_dp
    import fft_bram_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_W       = 6,
    parameter int OUT_REG      = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     En,
    output logic                     Busy,
    input  logic                     We_A,
    input  logic                     We_B,
    input  logic [ADDR_W-1:0]        Addr_A,
    input  logic [ADDR_W-1:0]        Addr_B,
    input  logic [word_w(WIDTH)-1:0] DI_A,
    input  logic [word_w(WIDTH)-1:0] DI_B,
    output logic [word_w(WIDTH)-1:0] DO_A,
    output logic [word_w(WIDTH)-1:0] DO_B,
    output logic                     Vld_A,
    output logic                     Vld_B,
    output logic                     Collision
);

    localparam int DW    = word_w(WIDTH);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DW-1:0]     ram_r [DEPTH];
    clr_state_e        state_r;
    clr_state_e        state_n;
    logic [ADDR_W-1:0] clr_cnt_r;

    logic          acc_s;
    logic          same_addr_s;
    logic          coll_s;
    logic          wr_b_s;
    logic [DW-1:0] rd_a_s;
    logic [DW-1:0] rd_b_s;
    logic [DW-1:0] rd_a_r;
    logic [DW-1:0] rd_b_r;
    logic          acc_r;
    logic          coll_q_r;
    logic          coll_r;

    assign Busy      = (state_r == CLEAR);
    assign acc_s     = En & ~Busy & ~Rst;
    assign Collision = coll_r;

    // Clear sequencer next state: leave CLEAR after the last address is zeroed.
    always_comb begin
        state_n = state_r;
        case (state_r)
            CLEAR: begin
                if (clr_cnt_r == {ADDR_W{1'b1}}) begin
                    state_n = READY;
                end else begin
                    state_n = CLEAR;
                end
            end
            READY:   state_n = READY;
            default: state_n = READY;
        endcase
    end

    // Clear sequencer state and address counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
            clr_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == CLEAR) begin
                clr_cnt_r <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Arbitration and read-during-write data selection; port A wins a shared-address write.
    always_comb begin
        same_addr_s = (Addr_A == Addr_B);
        coll_s      = acc_s & We_A & We_B & same_addr_s;
        wr_b_s      = acc_s & We_B & ~(We_A & same_addr_s);
        if ((RDW_MODE == RDW_WRITE_FIRST) && We_A) begin
            rd_a_s = DI_A;
        end else begin
            rd_a_s = ram_r[Addr_A];
        end
        if ((RDW_MODE == RDW_WRITE_FIRST) && We_B) begin
            rd_b_s = DI_B;
        end else begin
            rd_b_s = ram_r[Addr_B];
        end
    end

    // Storage array: clear writes own the array while Busy.
    always_ff @(posedge Clk) begin
        if (Busy) begin
            ram_r[clr_cnt_r] <= '0;
        end else begin
            if (acc_s && We_A) begin
                ram_r[Addr_A] <= DI_A;
            end
            if (wr_b_s) begin
                ram_r[Addr_B] <= DI_B;
            end
        end
    end

    // Array read register plus collision flag staged to line up with the first output stage.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_r    <= 1'b0;
            rd_a_r   <= '0;
            rd_b_r   <= '0;
            coll_q_r <= 1'b0;
            coll_r   <= 1'b0;
        end else begin
            acc_r    <= acc_s;
            coll_q_r <= coll_s;
            coll_r   <= coll_q_r;
            if (acc_s) begin
                rd_a_r <= rd_a_s;
                rd_b_r <= rd_b_s;
            end
        end
    end

    fft_bram_port_pipe #(.DW(DW), .OUT_REG(OUT_REG)) u_pipe_a (
        .Clk     (Clk),
        .Rst     (Rst),
        .Rd_Vld  (acc_r),
        .Rd_Data (rd_a_r),
        .DO      (DO_A),
        .Vld     (Vld_A)
    );

    fft_bram_port_pipe #(.DW(DW), .OUT_REG(OUT_REG)) u_pipe_b (
        .Clk     (Clk),
        .Rst     (Rst),
        .Rd_Vld  (acc_r),
        .Rd_Data (rd_b_r),
        .DO      (DO_B),
        .Vld     (Vld_B)
    );

endmodule

// File: tb/tb_fft_bram_dp.sv
// Scoreboard bench: two instances (read-first and write-first) share stimulus and a memory model.
module tb_fft_bram_dp;

    logic        Clk;
    logic        Rst;
    logic        En;
    logic        We_A;
    logic        We_B;
    logic [5:0]  Addr_A;
    logic [5:0]  Addr_B;
    logic [63:0] DI_A;
    logic [63:0] DI_B;

    logic [63:0] DO_A0, DO_B0, DO_A1, DO_B1;
    logic        Vld_A0, Vld_B0, Vld_A1, Vld_B1;
    logic        Busy0, Busy1, Coll0, Coll1;

    fft_bram_dp #(.WIDTH(32), .ADDR_W(6), .OUT_REG(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) dut_rf (
        .Clk(Clk), .Rst(Rst), .En(En), .Busy(Busy0),
        .We_A(We_A), .We_B(We_B), .Addr_A(Addr_A), .Addr_B(Addr_B),
        .DI_A(DI_A), .DI_B(DI_B), .DO_A(DO_A0), .DO_B(DO_B0),
        .Vld_A(Vld_A0), .Vld_B(Vld_B0), .Collision(Coll0)
    );

    fft_bram_dp #(.WIDTH(32), .ADDR_W(6), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RST(1)) dut_wf (
        .Clk(Clk), .Rst(Rst), .En(En), .Busy(Busy1),
        .We_A(We_A), .We_B(We_B), .Addr_A(Addr_A), .Addr_B(Addr_B),
        .DI_A(DI_A), .DI_B(DI_B), .DO_A(DO_A1), .DO_B(DO_B1),
        .Vld_A(Vld_A1), .Vld_B(Vld_B1), .Collision(Coll1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        int          due;
        int          ch;
        logic [63:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          col_q[$];
    logic [63:0] mem [64];
    logic [63:0] exp_do [4];
    logic        exp_vld [4];
    logic [63:0] obs_do [4];
    logic        obs_vld [4];
    int          edge_idx = 0;
    int          clr_left = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    assign obs_do[0] = DO_A0;  assign obs_vld[0] = Vld_A0;
    assign obs_do[1] = DO_B0;  assign obs_vld[1] = Vld_B0;
    assign obs_do[2] = DO_A1;  assign obs_vld[2] = Vld_A1;
    assign obs_do[3] = DO_B1;  assign obs_vld[3] = Vld_B1;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %h, expected %h", tag, edge_idx, obs, exp);
        end
    endtask

    // Model the edge, advance one clock, then compare every output against the scoreboard.
    task automatic tick();
        int          n;
        logic        was_rst;
        logic        exp_col;
        logic [63:0] old_a;
        logic [63:0] old_b;
        exp_t        e;
        n       = edge_idx + 1;
        was_rst = Rst;
        if (Rst) begin
            clr_left = 64;
            sb_q.delete();
            col_q.delete();
            for (int i = 0; i < 64; i++) mem[i] = 64'd0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else if (En) begin
            old_a = mem[Addr_A];
            old_b = mem[Addr_B];
            sb_q.push_back('{n + 2, 0, old_a});
            sb_q.push_back('{n + 2, 1, old_b});
            sb_q.push_back('{n + 2, 2, We_A ? DI_A : old_a});
            sb_q.push_back('{n + 2, 3, We_B ? DI_B : old_b});
            if (We_A) mem[Addr_A] = DI_A;
            if (We_B && !(We_A && Addr_A == Addr_B)) mem[Addr_B] = DI_B;
            if (We_A && We_B && Addr_A == Addr_B) col_q.push_back(n + 1);
        end
        @(posedge Clk);
        edge_idx = n;
        #1;
        if (was_rst) begin
            for (int ch = 0; ch < 4; ch++) exp_do[ch] = 64'd0;
        end
        for (int ch = 0; ch < 4; ch++) exp_vld[ch] = 1'b0;
        while (sb_q.size() != 0 && sb_q[0].due == edge_idx) begin
            e = sb_q.pop_front();
            exp_vld[e.ch] = 1'b1;
            exp_do[e.ch]  = e.data;
        end
        exp_col = 1'b0;
        if (col_q.size() != 0 && col_q[0] == edge_idx) begin
            exp_col = 1'b1;
            void'(col_q.pop_front());
        end
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("port%0d_vld_do", ch), {obs_vld[ch], obs_do[ch]}, {exp_vld[ch], exp_do[ch]});
        end
        check("busy_rf", {64'd0, Busy0}, {64'd0, (clr_left > 0)});
        check("busy_wf", {64'd0, Busy1}, {64'd0, (clr_left > 0)});
        check("collision_rf", {64'd0, Coll0}, {64'd0, exp_col});
        check("collision_wf", {64'd0, Coll1}, {64'd0, exp_col});
    endtask

    task automatic drive(input logic en, input logic wa, input logic [5:0] aa, input logic [63:0] da,
                         input logic wb, input logic [5:0] ab, input logic [63:0] db);
        En = en; We_A = wa; Addr_A = aa; DI_A = da;
        We_B = wb; Addr_B = ab; DI_B = db;
        tick();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    endtask

    initial begin
        Rst = 1'b1; En = 1'b0; We_A = 1'b0; We_B = 1'b0;
        Addr_A = 6'd0; Addr_B = 6'd0; DI_A = 64'd0; DI_B = 64'd0;

        // Reset, then attempt a write on every clear cycle: all must be discarded.
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 64; i++) drive(1'b1, 1'b1, 6'd7, 64'hDEAD, 1'b1, 6'd7, 64'hBEEF);
        drive(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 6'd31, 64'd0);
        drive(1'b1, 1'b0, 6'd63, 64'd0, 1'b0, 6'd7, 64'd0);
        idle(3);

        // Write with En low is ignored.
        drive(1'b0, 1'b1, 6'd8, 64'h55, 1'b0, 6'd0, 64'd0);
        drive(1'b1, 1'b0, 6'd8, 64'd0, 1'b0, 6'd8, 64'd0);
        idle(3);

        // Basic write on A, read back on B.
        drive(1'b1, 1'b1, 6'd5, 64'h0000_1234_0000_5678, 1'b0, 6'd0, 64'd0);
        drive(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 6'd5, 64'd0);
        idle(3);

        // Read-during-write on A with a cross-port read on B.
        drive(1'b1, 1'b1, 6'd9, 64'h11, 1'b0, 6'd0, 64'd0);
        drive(1'b1, 1'b1, 6'd9, 64'h22, 1'b0, 6'd9, 64'd0);
        drive(1'b1, 1'b0, 6'd9, 64'd0, 1'b0, 6'd9, 64'd0);
        idle(3);

        // Write/write collision on address 3, then read back.
        drive(1'b1, 1'b1, 6'd3, 64'hAA, 1'b1, 6'd3, 64'hBB);
        idle(1);
        drive(1'b1, 1'b0, 6'd3, 64'd0, 1'b0, 6'd3, 64'd0);
        idle(3);

        // En toggling on alternate cycles, then random traffic on a narrow address range.
        for (int i = 0; i < 8; i++) drive(i[0], 1'b0, 6'(i), 64'd0, 1'b0, 6'(63 - i), 64'd0);
        for (int i = 0; i < 40; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)),
                  {$urandom, $urandom});
        end

        // Reset during traffic, then reset again mid-clear at counter 20.
        drive(1'b1, 1'b0, 6'd1, 64'd0, 1'b0, 6'd2, 64'd0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        idle(20);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 64; i++) drive(1'b1, 1'b1, 6'd3, 64'h77, 1'b0, 6'd0, 64'd0);
        for (int i = 0; i < 64; i++) drive(1'b1, 1'b0, 6'(i), 64'd0, 1'b0, 6'(63 - i), 64'd0);
        idle(4);
        check("scoreboard_drained", 65'(sb_q.size() + col_q.size()), 65'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
